// File: rtl/axi_aw_allocator.sv
// Round-robin AW-channel allocator: N_TARG_PORT masters share one slave AW port and push winner IDs to a W-ID FIFO.
// Define AXI_AW_OUT_REG_EN to insert a one-entry output register slice; default is a zero-latency combinational path.
module axi_aw_allocator #(
  parameter int AXI_ADDRESS_W = 32,
  parameter int AXI_USER_W    = 6,
  parameter int N_TARG_PORT   = 7,
  parameter int LOG_N_TARG    = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1,
  parameter int AXI_ID_IN     = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [AXI_ID_IN-1:0]               awid_i     [N_TARG_PORT],
  input  logic [AXI_ADDRESS_W-1:0]           awaddr_i   [N_TARG_PORT],
  input  logic [7:0]                         awlen_i    [N_TARG_PORT],
  input  logic [2:0]                         awsize_i   [N_TARG_PORT],
  input  logic [1:0]                         awburst_i  [N_TARG_PORT],
  input  logic                               awlock_i   [N_TARG_PORT],
  input  logic [3:0]                         awcache_i  [N_TARG_PORT],
  input  logic [2:0]                         awprot_i   [N_TARG_PORT],
  input  logic [3:0]                         awregion_i [N_TARG_PORT],
  input  logic [3:0]                         awqos_i    [N_TARG_PORT],
  input  logic [AXI_USER_W-1:0]              awuser_i   [N_TARG_PORT],
  input  logic [N_TARG_PORT-1:0]             awvalid_i,
  output logic [N_TARG_PORT-1:0]             awready_o,
  output logic [AXI_ID_IN+LOG_N_TARG-1:0]    awid_o,
  output logic [AXI_ADDRESS_W-1:0]           awaddr_o,
  output logic [7:0]                         awlen_o,
  output logic [2:0]                         awsize_o,
  output logic [1:0]                         awburst_o,
  output logic                               awlock_o,
  output logic [3:0]                         awcache_o,
  output logic [2:0]                         awprot_o,
  output logic [3:0]                         awregion_o,
  output logic [3:0]                         awqos_o,
  output logic [AXI_USER_W-1:0]              awuser_o,
  output logic                               awvalid_o,
  input  logic                               awready_i,
  output logic                               push_ID_o,
  output logic [LOG_N_TARG+N_TARG_PORT-1:0]  ID_o,
  input  logic                               grant_FIFO_ID_i
);

  localparam logic [LOG_N_TARG-1:0] LAST_PORT = LOG_N_TARG'(N_TARG_PORT - 1);

  function automatic logic [N_TARG_PORT-1:0] oneHot(input logic [LOG_N_TARG-1:0] idx);
    return {{(N_TARG_PORT-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [LOG_N_TARG-1:0] nextPort(input logic [LOG_N_TARG-1:0] idx);
    return (idx == LAST_PORT) ? '0 : idx + 1'b1;
  endfunction

  logic [LOG_N_TARG-1:0] rr_q;
  logic [LOG_N_TARG-1:0] rr_d;
  logic [LOG_N_TARG-1:0] searchIdx;
  logic                  anyValid;
  logic                  found;
  int                    probe;

  assign anyValid = |awvalid_i;

  // Circular priority search starting at the round-robin pointer.
  always_comb begin
    searchIdx = '0;
    found     = 1'b0;
    probe     = 0;
    for (int i = 0; i < N_TARG_PORT; i++) begin
      probe = int'(rr_q) + i;
      if (probe >= N_TARG_PORT) probe = probe - N_TARG_PORT;
      if (!found && awvalid_i[probe]) begin
        found     = 1'b1;
        searchIdx = LOG_N_TARG'(probe);
      end
    end
  end

`ifdef AXI_AW_OUT_REG_EN

  logic                                capture;
  logic                                valid_q;
  logic [AXI_ID_IN+LOG_N_TARG-1:0]     id_q;
  logic [AXI_ADDRESS_W-1:0]            addr_q;
  logic [7:0]                          len_q;
  logic [2:0]                          size_q;
  logic [1:0]                          burst_q;
  logic                                lock_q;
  logic [3:0]                          cache_q;
  logic [2:0]                          prot_q;
  logic [3:0]                          region_q;
  logic [3:0]                          qos_q;
  logic [AXI_USER_W-1:0]               user_q;
  logic [LOG_N_TARG+N_TARG_PORT-1:0]   fifoId_q;

  // The slice accepts a new winner when empty or emptying this cycle, and the ID FIFO has room.
  assign capture   = anyValid & grant_FIFO_ID_i & (~valid_q | awready_i) & rst_n;
  assign rr_d      = capture ? nextPort(searchIdx) : rr_q;
  assign push_ID_o = capture;
  assign awready_o = capture ? oneHot(searchIdx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      lock_q   <= 1'b0;
      cache_q  <= '0;
      prot_q   <= '0;
      region_q <= '0;
      qos_q    <= '0;
      user_q   <= '0;
      fifoId_q <= '0;
    end else begin
      rr_q <= rr_d;
      if (capture) begin
        valid_q  <= 1'b1;
        id_q     <= {searchIdx, awid_i[searchIdx]};
        addr_q   <= awaddr_i[searchIdx];
        len_q    <= awlen_i[searchIdx];
        size_q   <= awsize_i[searchIdx];
        burst_q  <= awburst_i[searchIdx];
        lock_q   <= awlock_i[searchIdx];
        cache_q  <= awcache_i[searchIdx];
        prot_q   <= awprot_i[searchIdx];
        region_q <= awregion_i[searchIdx];
        qos_q    <= awqos_i[searchIdx];
        user_q   <= awuser_i[searchIdx];
        fifoId_q <= {searchIdx, oneHot(searchIdx)};
      end else if (awready_i) begin
        valid_q  <= 1'b0;
      end
    end
  end

  assign awvalid_o  = valid_q;
  assign awid_o     = id_q;
  assign awaddr_o   = addr_q;
  assign awlen_o    = len_q;
  assign awsize_o   = size_q;
  assign awburst_o  = burst_q;
  assign awlock_o   = lock_q;
  assign awcache_o  = cache_q;
  assign awprot_o   = prot_q;
  assign awregion_o = region_q;
  assign awqos_o    = qos_q;
  assign awuser_o   = user_q;
  assign ID_o       = fifoId_q;

`else

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } lockState_e;

  lockState_e            lock_q;
  logic [LOG_N_TARG-1:0] lockIdx_q;
  logic [LOG_N_TARG-1:0] selIdx;

  assign selIdx    = (lock_q == ARB_LOCKED) ? lockIdx_q : searchIdx;
  assign awvalid_o = anyValid & grant_FIFO_ID_i & rst_n;
  assign push_ID_o = awvalid_o & awready_i;
  assign awready_o = push_ID_o ? oneHot(selIdx) : '0;
  assign rr_d      = push_ID_o ? nextPort(selIdx) : rr_q;

  // A presented but unaccepted request pins the winner until its handshake; an ID FIFO stall keeps the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= '0;
      lock_q    <= ARB_FREE;
      lockIdx_q <= '0;
    end else begin
      rr_q <= rr_d;
      if (push_ID_o) begin
        lock_q <= ARB_FREE;
      end else if (awvalid_o) begin
        lock_q    <= ARB_LOCKED;
        lockIdx_q <= selIdx;
      end else if (!anyValid) begin
        lock_q <= ARB_FREE;
      end
    end
  end

  assign awid_o     = {selIdx, awid_i[selIdx]};
  assign awaddr_o   = awaddr_i[selIdx];
  assign awlen_o    = awlen_i[selIdx];
  assign awsize_o   = awsize_i[selIdx];
  assign awburst_o  = awburst_i[selIdx];
  assign awlock_o   = awlock_i[selIdx];
  assign awcache_o  = awcache_i[selIdx];
  assign awprot_o   = awprot_i[selIdx];
  assign awregion_o = awregion_i[selIdx];
  assign awqos_o    = awqos_i[selIdx];
  assign awuser_o   = awuser_i[selIdx];
  assign ID_o       = {selIdx, oneHot(selIdx)};

`endif

endmodule

// File: tb/tb_axi_aw_allocator.sv
// Directed self-checking bench for axi_aw_allocator with 7 ports; covers the AXI_AW_OUT_REG_EN slice build too.
module tb_axi_aw_allocator;

  localparam int N   = 7;
  localparam int LOG = 3;
  localparam int IDW = 16;
  localparam int AW  = 32;
  localparam int UW  = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [IDW-1:0] awid_i     [N];
  logic [AW-1:0]  awaddr_i   [N];
  logic [7:0]     awlen_i    [N];
  logic [2:0]     awsize_i   [N];
  logic [1:0]     awburst_i  [N];
  logic           awlock_i   [N];
  logic [3:0]     awcache_i  [N];
  logic [2:0]     awprot_i   [N];
  logic [3:0]     awregion_i [N];
  logic [3:0]     awqos_i    [N];
  logic [UW-1:0]  awuser_i   [N];
  logic [N-1:0]   awvalid_i;
  logic [N-1:0]   awready_o;
  logic [IDW+LOG-1:0] awid_o;
  logic [AW-1:0]  awaddr_o;
  logic [7:0]     awlen_o;
  logic [2:0]     awsize_o;
  logic [1:0]     awburst_o;
  logic           awlock_o;
  logic [3:0]     awcache_o;
  logic [2:0]     awprot_o;
  logic [3:0]     awregion_o;
  logic [3:0]     awqos_o;
  logic [UW-1:0]  awuser_o;
  logic           awvalid_o;
  logic           awready_i;
  logic           push_ID_o;
  logic [LOG+N-1:0] ID_o;
  logic           grant_FIFO_ID_i;

  int testsRun    = 0;
  int testsFailed = 0;
  int pushCount;

  always #5 clk = ~clk;

  axi_aw_allocator dut (
    .clk(clk), .rst_n(rst_n),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awlock_i(awlock_i), .awcache_i(awcache_i), .awprot_i(awprot_i),
    .awregion_i(awregion_i), .awqos_i(awqos_i), .awuser_i(awuser_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awlock_o(awlock_o), .awcache_o(awcache_o), .awprot_o(awprot_o),
    .awregion_o(awregion_o), .awqos_o(awqos_o), .awuser_o(awuser_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .push_ID_o(push_ID_o), .ID_o(ID_o), .grant_FIFO_ID_i(grant_FIFO_ID_i)
  );

  function automatic logic [IDW-1:0] idOf(input int k);
    return 16'hA000 + 16'(k);
  endfunction

  function automatic logic [AW-1:0] addrOf(input int k);
    return 32'h4000_0000 + 32'(k) * 32'h100;
  endfunction

  function automatic logic [7:0] lenOf(input int k);
    return 8'(k * 3 + 1);
  endfunction

  // Drive one cycle of stimulus mid-cycle, then let the combinational outputs settle.
  task automatic applyStimulus(input logic [N-1:0] valid, input logic ready, input logic grant);
    @(negedge clk);
    awvalid_i       = valid;
    awready_i       = ready;
    grant_FIFO_ID_i = grant;
    #1;
  endtask

  // expK: port whose payload must be on the output; readyIdx: port being accepted this cycle, or -1.
  task automatic checkOutput(input string tag, input logic expValid, input int expK, input int readyIdx);
    logic [N-1:0]       expReady;
    logic               expPush;
    logic [IDW+LOG-1:0] expId;
    logic [LOG+N-1:0]   expFifo;
    expPush  = (readyIdx >= 0);
    expReady = expPush ? (7'b0000001 << readyIdx) : 7'b0;
    expId    = {3'(expK), idOf(expK)};
    expFifo  = {3'(expK), 7'b0000001 << expK};
    testsRun++;
    assert (awvalid_o === expValid) else begin
      testsFailed++;
      $error("[TB] FAIL %s awvalid_o: observed %b expected %b", tag, awvalid_o, expValid);
    end
    testsRun++;
    assert (push_ID_o === expPush) else begin
      testsFailed++;
      $error("[TB] FAIL %s push_ID_o: observed %b expected %b", tag, push_ID_o, expPush);
    end
    testsRun++;
    assert (awready_o === expReady) else begin
      testsFailed++;
      $error("[TB] FAIL %s awready_o: observed %b expected %b", tag, awready_o, expReady);
    end
    if (expValid) begin
      testsRun++;
      assert (awid_o === expId) else begin
        testsFailed++;
        $error("[TB] FAIL %s awid_o: observed %h expected %h", tag, awid_o, expId);
      end
      testsRun++;
      assert (ID_o === expFifo) else begin
        testsFailed++;
        $error("[TB] FAIL %s ID_o: observed %b expected %b", tag, ID_o, expFifo);
      end
      testsRun++;
      assert ((awaddr_o === addrOf(expK)) && (awlen_o === lenOf(expK))) else begin
        testsFailed++;
        $error("[TB] FAIL %s payload: observed %h/%h expected %h/%h", tag, awaddr_o, awlen_o, addrOf(expK), lenOf(expK));
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    awvalid_i = '0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int p = 0; p < N; p++) begin
      awid_i[p]     = idOf(p);
      awaddr_i[p]   = addrOf(p);
      awlen_i[p]    = lenOf(p);
      awsize_i[p]   = 3'(p);
      awburst_i[p]  = 2'(p);
      awlock_i[p]   = p[0];
      awcache_i[p]  = 4'(p + 1);
      awprot_i[p]   = 3'(p + 2);
      awregion_i[p] = 4'(p + 3);
      awqos_i[p]    = 4'(p + 4);
      awuser_i[p]   = 6'(p + 5);
    end
    rst_n           = 1'b0;
    awvalid_i       = '0;
    awready_i       = 1'b0;
    grant_FIFO_ID_i = 1'b0;
    #12;
    checkOutput("rst_idle", 1'b0, 0, -1);
    awvalid_i       = 7'h7F;
    awready_i       = 1'b1;
    grant_FIFO_ID_i = 1'b1;
    #1;
    checkOutput("rst_gated", 1'b0, 0, -1);
    awvalid_i = '0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef AXI_AW_OUT_REG_EN
    applyStimulus(7'b0100000, 1'b1, 1'b1);
    checkOutput("slice_capture", 1'b0, 0, 5);
    applyStimulus(7'b0000000, 1'b1, 1'b1);
    checkOutput("slice_out", 1'b1, 5, -1);
    applyStimulus(7'b0000000, 1'b1, 1'b1);
    checkOutput("slice_drain", 1'b0, 0, -1);
    applyStimulus(7'b0000011, 1'b1, 1'b1);
    checkOutput("tput_cap0", 1'b0, 0, 0);
    applyStimulus(7'b0000011, 1'b1, 1'b1);
    checkOutput("tput_cap1", 1'b1, 0, 1);
    applyStimulus(7'b0000011, 1'b1, 1'b1);
    checkOutput("tput_cap0b", 1'b1, 1, 0);
    applyStimulus(7'b0000010, 1'b0, 1'b1);
    checkOutput("slice_full", 1'b1, 0, -1);
    applyStimulus(7'b0000010, 1'b1, 1'b1);
    checkOutput("slice_refill", 1'b1, 0, 1);
`else
    applyStimulus(7'b0000000, 1'b1, 1'b1);
    checkOutput("idle", 1'b0, 0, -1);

    applyStimulus(7'b0000101, 1'b1, 1'b1);
    checkOutput("rr_first", 1'b1, 0, 0);
    applyStimulus(7'b0000101, 1'b1, 1'b1);
    checkOutput("rr_second", 1'b1, 2, 2);

    doReset();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(7'b0001010, 1'b0, 1'b1);
      checkOutput($sformatf("hold_c%0d", c), 1'b1, 1, -1);
    end
    applyStimulus(7'b0001011, 1'b0, 1'b1);
    checkOutput("no_preempt", 1'b1, 1, -1);
    applyStimulus(7'b0001011, 1'b0, 1'b0);
    checkOutput("grant_drop", 1'b0, 0, -1);
    applyStimulus(7'b0001011, 1'b1, 1'b1);
    checkOutput("hold_release", 1'b1, 1, 1);
    applyStimulus(7'b0001001, 1'b1, 1'b1);
    checkOutput("after_lock", 1'b1, 3, 3);

    applyStimulus(7'b0010000, 1'b1, 1'b0);
    checkOutput("fifo_full", 1'b0, 0, -1);
    applyStimulus(7'b0010000, 1'b1, 1'b1);
    checkOutput("fifo_free", 1'b1, 4, 4);

    doReset();
    pushCount = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(7'h7F, 1'b1, 1'b1);
      checkOutput($sformatf("all_c%0d", c), 1'b1, c % N, c % N);
      if (push_ID_o === 1'b1) pushCount++;
    end
    testsRun++;
    assert (pushCount === 8) else begin
      testsFailed++;
      $error("[TB] FAIL push_count: observed %0d expected %0d", pushCount, 8);
    end

    applyStimulus(7'b0101000, 1'b0, 1'b1);
    checkOutput("pre_reset", 1'b1, 3, -1);
    #2;
    rst_n     = 1'b0;
    awvalid_i = 7'b0001001;
    awready_i = 1'b1;
    #1;
    checkOutput("reset_mid", 1'b0, 0, -1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_first", 1'b1, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/axi_aw_allocator.md
AXI_AW_ALLOCATOR -- requirements
Module: axi_aw_allocator

Interface
REQ-001 SHALL have parameter AXI_ADDRESS_W, default 32, meaning address width.
REQ-002 SHALL have parameter AXI_USER_W, default 6, meaning awuser width.
REQ-003 SHALL have parameter N_TARG_PORT, default 7, meaning number of competing input ports.
REQ-004 SHALL have parameter LOG_N_TARG, default ceil(log2(N_TARG_PORT)) with a minimum of 1, meaning port-index width.
REQ-005 SHALL have parameter AXI_ID_IN, default 16, meaning input ID width; output ID width is AXI_ID_IN+LOG_N_TARG.
REQ-006 SHALL have clk, input, 1, clock; rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have per-port inputs, each an array of N_TARG_PORT elements: awid_i [AXI_ID_IN], awaddr_i [AXI_ADDRESS_W], awlen_i [8], awsize_i [3], awburst_i [2], awlock_i [1], awcache_i [4], awprot_i [3], awregion_i [4], awqos_i [4], awuser_i [AXI_USER_W].
REQ-008 SHALL have awvalid_i, input, N_TARG_PORT, per-port request; awready_o, output, N_TARG_PORT, per-port accept.
REQ-009 SHALL have slave-side outputs awid_o [AXI_ID_IN+LOG_N_TARG], plus awaddr_o, awlen_o, awsize_o, awburst_o, awlock_o, awcache_o, awprot_o, awregion_o, awqos_o and awuser_o at the input widths; awvalid_o, output, 1; awready_i, input, 1.
REQ-010 SHALL have push_ID_o, output, 1, push strobe to the write-data ID FIFO; ID_o, output, LOG_N_TARG+N_TARG_PORT, {BIN index, one-hot}; grant_FIFO_ID_i, input, 1, FIFO not full.

Function
REQ-011 SHALL arbitrate round-robin: search from pointer rr_q upward, wrapping at N_TARG_PORT-1 to 0; the first asserted awvalid_i wins (index k).
REQ-012 SHALL set rr_q to (k+1) mod N_TARG_PORT on each accepted transfer; rr_q SHALL be unchanged otherwise.
REQ-013 SHALL hold the winner fixed (lock_q=1, locked index stored) while awvalid_o=1 and awready_i=0; new requests SHALL NOT preempt it.
REQ-014 SHALL drive awvalid_o = (any awvalid_i) & grant_FIFO_ID_i; no request SHALL be presented while the ID FIFO is full.
REQ-015 SHALL assert awready_o[k] = awready_i & grant_FIFO_ID_i for the winner only; all other bits SHALL be 0.
REQ-016 SHALL assert push_ID_o = awvalid_o & awready_i, in the same cycle as the slave AW handshake, exactly once per transfer.
REQ-017 SHALL drive ID_o = {k[LOG_N_TARG-1:0], one-hot(k)}, valid whenever awvalid_o=1.
REQ-018 SHALL drive awid_o = {k, awid_i[k]}; all other payload outputs SHALL be the winner's fields passed through unchanged.
REQ-019 Zero-latency path: request to awvalid_o in the same cycle.
REQ-020 Back-to-back transfers SHALL be supported at one per cycle while awready_i and grant_FIFO_ID_i stay high.
REQ-021 Relies on grant_FIFO_ID_i deasserting only in the cycle after a push; a drop with awvalid_o=1 is an upstream protocol error, and the lock SHALL then be held.
REQ-022 With no awvalid_i asserted: awvalid_o=0, push_ID_o=0, awready_o=0.

Reset
REQ-023 On rst_n=0, asynchronously: rr_q=0, lock_q=0, all output registers cleared; awvalid_o=0, push_ID_o=0, awready_o=0.
REQ-024 Reset mid-transfer SHALL discard the pending grant; no push SHALL occur until after reset release.

Configuration
REQ-025 Macro AXI_AW_OUT_REG_EN defined: a one-entry output register slice is inserted.
  - Winner captured when the slice is empty, or draining (awready_i=1), and grant_FIFO_ID_i=1.
  - push_ID_o asserted on capture; awready_o[k] pulses in the capture cycle.
  - awvalid_o/awid_o/payload/ID_o come from the slice; one cycle of latency; full throughput preserved.
REQ-026 Macro AXI_AW_OUT_REG_EN undefined: the combinational path of REQ-014..REQ-019 applies.

Verification
REQ-027 Reset, then awvalid_i=7'b0000101, awready_i=1, grant=1 -> port0 wins cycle1 (ID_o={3'd0,7'b0000001}), port2 wins cycle2, one push each.
REQ-028 Ports 1 and 3 requesting, awready_i=0 for 4 cycles -> awvalid_o held high, awid_o={1,awid_i[1]} stable throughout, no push, awready_o=0.
REQ-029 grant_FIFO_ID_i=0 with port 4 requesting -> awvalid_o=0, push_ID_o=0, awready_o=0; grant rises -> transfer completes and push occurs in the same cycle.
REQ-030 All 7 ports requesting continuously, awready_i=1 -> grant order 0,1,2,3,4,5,6,0, with 8 pushes in 8 cycles.
REQ-031 rst_n pulsed low while awvalid_o=1 and awready_i=0 -> outputs zero immediately, rr_q=0, and after release port 0 is granted first.
REQ-032 With AXI_AW_OUT_REG_EN: single request from port 5 -> push_ID_o at cycle 0, awvalid_o at cycle 1, awid_o={3'd5,awid_i[5]}.
